pam_mul_arbiter: RTL and testbench

- Shares one approximate unsigned 8x8 multiplier (16-bit product) among NREQ requesters.
- Per-requester valid/ready request ports; round-robin grant.
- Drives the multiplier operands, waits a fixed multiplier latency, then returns the tagged product on a single valid/ready response port.
- Sits between the accelerator's operand producers and the shared PAM multiplier instance.

---
 rtl/pam_mul_arbiter.sv | 145 ++++++++++++++
 tb/tb_pam_mul_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pam_mul_arbiter.sv
// Round-robin arbiter sharing one approximate 8x8 multiplier among NREQ requesters.
// Define PAM_ERR_MON_EN to build the exact-product error monitor driving err_cnt.
module pam_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_x,
    input  logic [8*NREQ-1:0] req_y,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        mul_x,
    output logic [7:0]        mul_y,
    input  logic [15:0]       mul_z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_z,
    output logic              busy,
    output logic [15:0]       err_cnt
);

    localparam int CW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        OPER,
        RESP
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [IDW-1:0] last;
    logic [IDW-1:0] id;
    logic [IDW-1:0] g;
    logic [CW-1:0]  cnt;
    logic [7:0]     op_x;
    logic [7:0]     op_y;
    logic [7:0]     sel_x;
    logic [7:0]     sel_y;
    logic           any;
    logic           accept;
    logic           capture;

    // Cyclic search starting just after the last winner.
    always_comb begin
        g   = last;
        any = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!any && req_valid[(int'(last) + k) % NREQ]) begin
                any = 1'b1;
                g   = IDW'((int'(last) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (g == IDW'(i)) begin
                sel_x = req_x[8*i +: 8];
                sel_y = req_y[8*i +: 8];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any) begin
            req_ready[g] = 1'b1;
        end
    end

    assign accept  = (state == IDLE) && any;
    assign capture = (state == OPER) && (cnt == '0);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any) state_nx = OPER;
            OPER:    if (cnt == '0) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= IDW'(NREQ - 1);
            id        <= '0;
            cnt       <= '0;
            op_x      <= '0;
            op_y      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_x <= sel_x;
                op_y <= sel_y;
                id   <= g;
                last <= g;
                cnt  <= CW'(MUL_LAT);
            end else if (state == OPER && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (capture) begin
                rsp_z     <= mul_z;
                rsp_id    <= id;
                rsp_valid <= 1'b1;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign mul_x = op_x;
    assign mul_y = op_y;
    assign busy  = (state != IDLE);

`ifdef PAM_ERR_MON_EN
    logic [15:0] exact;
    logic [15:0] err_q;

    assign exact = {8'b0, op_x} * {8'b0, op_y};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (capture && mul_z != exact && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_pam_mul_arbiter.sv
// Randomized self-checking bench for pam_mul_arbiter against a
// transaction-level model (round-robin pick, fixed latency, product).
module tb_pam_mul_arbiter;

    parameter int MUL_LAT = 1;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int PL   = (MUL_LAT > 0) ? MUL_LAT : 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_x = '0;
    logic [8*NREQ-1:0] req_y = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        mul_x;
    logic [7:0]        mul_y;
    logic [15:0]       mul_z;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_z;
    logic              busy;
    logic [15:0]       err_cnt;
    logic              bad = 1'b0;

    pam_mul_arbiter #(
        .NREQ(NREQ),
        .IDW(IDW),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_x(req_x),
        .req_y(req_y),
        .req_ready(req_ready),
        .mul_x(mul_x),
        .mul_y(mul_y),
        .mul_z(mul_z),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_z(rsp_z),
        .busy(busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: exact product, minus one when bad is set.
    logic [15:0] prod;
    logic [15:0] pipe [PL];
    assign prod = ({8'b0, mul_x} * {8'b0, mul_y}) - {15'b0, bad};
    always @(posedge clk) begin
        pipe[0] <= prod;
        for (int i = 1; i < PL; i++) pipe[i] <= pipe[i-1];
    end
    assign mul_z = (MUL_LAT == 0) ? prod : pipe[PL-1];

    int errors = 0;
    int checks = 0;
    int m_last;
    int m_err;
    int last_acc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] m);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int exp_err();
`ifdef PAM_ERR_MON_EN
        return m_err;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_z", rsp_z, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mulx", mul_x, 0);
        chk("rst_muly", mul_y, 0);
        chk("rst_err", err_cnt, 0);
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        m_err  = 0;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] mask,
                           input logic [8*NREQ-1:0] xs,
                           input logic [8*NREQ-1:0] ys,
                           input bit b, input int hold,
                           input bit ii_chk);
        int          g;
        int          k;
        logic [15:0] ez;
        logic [15:0] z0;
        logic [IDW-1:0] id0;
        req_valid = mask;
        req_x     = xs;
        req_y     = ys;
        bad       = b;
        rsp_ready = (hold == 0);
        #1;
        g = pick(mask);
        chk("grant", req_ready, 1 << g);
        chk("idle_busy", busy, 0);
        @(posedge clk);
        #1;
        if (ii_chk) chk("ii", cyc - last_acc, MUL_LAT + 3);
        last_acc = cyc;
        m_last   = g;
        chk("oper_ready", req_ready, 0);
        chk("oper_busy", busy, 1);
        chk("op_x", mul_x, xs[8*g +: 8]);
        chk("op_y", mul_y, ys[8*g +: 8]);
        ez = {8'b0, xs[8*g +: 8]} * {8'b0, ys[8*g +: 8]};
        ez = ez - {15'b0, b};
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", k, MUL_LAT + 1);
        chk("rsp_id", rsp_id, g);
        chk("rsp_z", rsp_z, ez);
        z0  = rsp_z;
        id0 = rsp_id;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", rsp_valid, 1);
            chk("hold_z", rsp_z, z0);
            chk("hold_id", rsp_id, id0);
            chk("hold_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_drop", rsp_valid, 0);
        chk("back_idle", busy, 0);
        m_err += int'(b);
        chk("err_cnt", err_cnt, exp_err());
    endtask

    initial begin
        logic [NREQ-1:0]   mask;
        logic [8*NREQ-1:0] xs;
        logic [8*NREQ-1:0] ys;

        do_reset();

        // Single request from requester 2
        run_txn(4'b0100, {8'd0, 8'd13, 8'd0, 8'd0},
                {8'd0, 8'd11, 8'd0, 8'd0}, 1'b0, 0, 1'b0);

        // All valid: order 0,1,2,3,0 at the minimum interval
        do_reset();
        for (int t = 0; t < 5; t++) begin
            run_txn(4'hF, $urandom, $urandom, 1'b0, 0, t != 0);
        end

        // Backpressure
        run_txn(4'b1010, $urandom, $urandom, 1'b0, 5, 1'b0);

        // Reset while in OPER
        req_valid = 4'b0010;
        req_x     = $urandom;
        req_y     = $urandom;
        bad       = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", busy, 1);
        rst_n     = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("mid_valid", rsp_valid, 0);
        chk("mid_idle", busy, 0);
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        m_err  = 0;
        run_txn(4'b0011, $urandom, $urandom, 1'b0, 0, 1'b0);

        // Largest operands
        run_txn(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
        chk("max_z", rsp_z, 16'd65025);

        // Three approximate products, two exact
        do_reset();
        for (int t = 0; t < 5; t++) begin
            run_txn(4'hF, $urandom, $urandom, t < 3, 0, 1'b0);
        end
`ifdef PAM_ERR_MON_EN
        chk("err_total", err_cnt, 3);
`else
        chk("err_total", err_cnt, 0);
`endif

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            mask = 4'($urandom_range(1, 15));
            xs   = $urandom;
            ys   = $urandom;
            run_txn(mask, xs, ys, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'b0);
        end

        req_valid = '0;
        #1;
        chk("final_ready", req_ready, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
